led_chaser: RTL and testbench
=============================

# led_chaser

Parametrised LED pattern engine for the board-demo top level. It drives a WIDTH-bit LED bus with one of five selectable animations: rotate left, rotate right, bounce, blink and fill. Pattern steps are paced by a programmable prescaler, and the pattern can be paused and single-stepped. It sits between the switch/button inputs and the `ledr` output pins, and replaces the fixed 16-bit left rotator.

## Interface
- `WIDTH`, 16: LED count, ≥2.
- `DIV`, 5000000: clocks per step at speed 0, ≥1.
- `CNT_W`, 32: prescaler counter width; must hold DIV-1.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `mode`  in  3: requested animation (encodings below).
- `speed`  in  2: period = DIV >> speed, floored at 1.
- `pause`  in  1: level; freezes prescaler and pattern.
- `step`  in  1: one-cycle pulse; honoured only while `pause`=1.
- `ledr`  out  WIDTH: current pattern.
- `tick`  out  1: one-cycle pulse on every advance event.
- `mode_q`  out  3: mode currently in effect.

## Operation
- Mode encodings:
  - 0 ROT_L
  - 1 ROT_R
  - 2 BOUNCE
  - 3 BLINK
  - 4 FILL
  - 5–7 HOLD (pattern frozen; ticks still issued).
- Advance event: prescaler wrap while `pause`=0, or `step`=1 while `pause`=1. `tick` is 1 in exactly the cycle the event is registered.
- On an advance event with `mode` ≠ `mode_q`:
  - `mode_q` ← `mode`.
  - `ledr` loads the init pattern of the new mode, with no advance on that event.
  - `dir` ← left.
- Init patterns: ROT_L/ROT_R/BOUNCE = 1 (LSB); BLINK = all ones; FILL = 0; HOLD keeps `ledr`.
- Otherwise `ledr` advances per `mode_q`:
  - ROT_L: {l[W-2:0], l[W-1]}.
  - ROT_R: {l[0], l[W-1:1]}.
  - BOUNCE: single bit shifts in `dir`. It reverses on reaching bit W-1 (then moves right) or bit 0 (then moves left). Each endpoint is shown for exactly one step. Full cycle is 2W-2 steps.
  - BLINK: ~l.
  - FILL: if l = all ones then 0, else {l[W-2:0],1'b1}. Cycle is W+1 steps.
  - HOLD: unchanged.
- Prescaler counter `cnt`:
  - Counts 0..period-1.
  - Wraps when `cnt` ≥ period-1, so a speed increase never overruns.
  - Holds its value while `pause`=1.
  - Resumes from the held value when `pause` returns to 0.
- `step` while `pause`=0 is ignored. Pause asserted in the same cycle as a wrap suppresses that tick.
- Reset values: `ledr`=1, `mode_q`=0, `tick`=0, `cnt`=0, `dir`=left. Reset mid-pattern restores these immediately (asynchronous) and restarts the period on release.

## Timing
- All outputs are registered.
- `ledr` changes in the cycle after the prescaler hits period-1, coincident with `tick`=1.
- Unpaused, consecutive ticks are exactly `period` clocks apart. Example: DIV=4, speed=1 gives ticks every 2 clocks.
- `step` to `ledr` update takes 1 clock.
- `mode` is sampled only at advance events, so a mode change takes effect within ≤ period clocks.
- `speed` is sampled every cycle; the new period applies from the current count.

## Structure
- Package `led_pkg`: mode encodings (`MODE_ROT_L`…`MODE_FILL`), direction constants, and a `speed` → shift helper.
- Sub-module `led_tick`: prescaler with inputs DIV/CNT_W, `speed`, `pause` and output `wrap`.
- `led_chaser` holds `mode_q`, `dir`, the pattern register and the advance mux.

## Test plan
- Reset, WIDTH=8, DIV=4, speed=0, mode=0: `ledr`=01 after release. Ticks every 4 clocks; `ledr` goes 02, 04 … 80, then 01.
- mode=2, WIDTH=4, DIV=1: `ledr` sequence 1,2,4,8,4,2,1,2; `mode_q`=2 from the first tick.
- mode=4, WIDTH=4: the first tick loads 0; subsequent ticks give 1,3,7,F,0,1.
- pause=1 mid-period, then three single-cycle `step` pulses in ROT_L from 01: `ledr` goes 02, 04, 08, with `tick` once per step. Deassert pause: the next tick arrives after the remaining held count.
- Switch speed 0→3 with DIV=16 while `cnt`=10: wrap on the next cycle, then ticks every 2 clocks. mode=6 afterwards: `ledr` frozen while `tick` continues.
- Assert `rst_n`=0 asynchronously mid-BLINK with `ledr`=FF: `ledr`=01, `mode_q`=0 and `tick`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode/direction encodings and speed helper for the LED chaser
package led_pkg;

  localparam logic [2:0] MODE_ROT_L  = 3'd0;
  localparam logic [2:0] MODE_ROT_R  = 3'd1;
  localparam logic [2:0] MODE_BOUNCE = 3'd2;
  localparam logic [2:0] MODE_BLINK  = 3'd3;
  localparam logic [2:0] MODE_FILL   = 3'd4;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Each speed step halves the step period.
  function automatic int unsigned speed_shift(input logic [1:0] speed);
    return 32'(speed);
  endfunction

endpackage

// File: rtl/led_chaser_if.sv
// rtl/led_chaser_if.sv - control and pattern signals of the LED chaser
interface led_chaser_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       mode;
  logic [1:0]       speed;
  logic             pause;
  logic             step;
  logic [WIDTH-1:0] ledr;
  logic             tick;
  logic [2:0]       mode_q;

  modport master (output mode, speed, pause, step, input ledr, tick, mode_q);
  modport slave  (input mode, speed, pause, step, output ledr, tick, mode_q);
endinterface

// File: rtl/led_tick.sv
// rtl/led_tick.sv - pausable prescaler producing one wrap per step period
module led_tick
  import led_pkg::*;
#(
  parameter int unsigned DIV   = 5000000,
  parameter int          CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic       pause,
  output logic       wrap
);
  localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] last;

  always_comb begin
    period = DIV_C >> speed_shift(speed);
    last   = (period == '0) ? '0 : period - CNT_W'(1);
  end

  // >= rather than == so a sudden speed-up cannot run past the new period.
  assign wrap = !pause && (cnt >= last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/led_chaser.sv
// rtl/led_chaser.sv - selectable LED animation engine with prescaler, pause and single step
module led_chaser
  import led_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter int unsigned DIV   = 5000000,
  parameter int          CNT_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  led_chaser_if.slave   bus
);
  logic [WIDTH-1:0] led;
  logic [WIDTH-1:0] init_led;
  logic [WIDTH-1:0] next_led;
  logic [2:0]       mode_q;
  dir_e             dir;
  logic             tick;
  logic             wrap;
  logic             adv;
  logic             go_right;

  led_tick #(.DIV(DIV), .CNT_W(CNT_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .speed (bus.speed),
    .pause (bus.pause),
    .wrap  (wrap)
  );

  assign adv = wrap | (bus.pause & bus.step);

  // Bounce turns around at either end so each endpoint is shown once.
  assign go_right = led[WIDTH-1] | ((dir == DIR_RIGHT) & ~led[0]);

  always_comb begin
    init_led = led;
    case (bus.mode)
      MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE: init_led = WIDTH'(1);
      MODE_BLINK:                          init_led = '1;
      MODE_FILL:                           init_led = '0;
      default:                             init_led = led;
    endcase
  end

  always_comb begin
    next_led = led;
    case (mode_q)
      MODE_ROT_L:  next_led = {led[WIDTH-2:0], led[WIDTH-1]};
      MODE_ROT_R:  next_led = {led[0], led[WIDTH-1:1]};
      MODE_BOUNCE: next_led = go_right ? (led >> 1) : (led << 1);
      MODE_BLINK:  next_led = ~led;
      MODE_FILL:   next_led = (&led) ? '0 : {led[WIDTH-2:0], 1'b1};
      default:     next_led = led;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led    <= WIDTH'(1);
      mode_q <= MODE_ROT_L;
      dir    <= DIR_LEFT;
      tick   <= 1'b0;
    end else begin
      tick <= adv;
      if (adv) begin
        if (bus.mode != mode_q) begin
          mode_q <= bus.mode;
          led    <= init_led;
          dir    <= DIR_LEFT;
        end else begin
          led <= next_led;
          if (mode_q == MODE_BOUNCE) dir <= go_right ? DIR_RIGHT : DIR_LEFT;
        end
      end
    end
  end

  assign bus.ledr   = led;
  assign bus.tick   = tick;
  assign bus.mode_q = mode_q;
endmodule

// File: tb/tb_led_chaser.sv
// tb/tb_led_chaser.sv - self-checking bench for led_chaser: vector table, corner sequences, random vs model
module tb_led_chaser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_chaser_if #(.WIDTH(8)) ia ();
  led_chaser_if #(.WIDTH(4)) ib ();

  led_chaser #(.WIDTH(8), .DIV(16), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  led_chaser #(.WIDTH(4), .DIV(1),  .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] mode;
    logic       pause;
    logic       step;
    logic [3:0] led;
    logic       tick;
    logic [2:0] mq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int m, input int p, input int s, input int l, input int t, input int q);
    vec_t v;
    v.mode = 3'(m); v.pause = 1'(p); v.step = 1'(s);
    v.led  = 4'(l); v.tick  = 1'(t); v.mq   = 3'(q);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ia.tick && n < budget);
    if (!ia.tick) begin
      total++; bad++;
      $display("FAIL tick_timeout: no tick within %0d clocks", budget);
    end
  endtask

  // Reference pattern for WIDTH=8 from the number of steps taken since the mode was entered.
  function automatic int model_led(input int mq, input int p, input int hv);
    int w = 8;
    int k;
    case (mq)
      0: return 1 << (p % w);
      1: return 1 << ((w - (p % w)) % w);
      2: begin
        k = p % (2 * w - 2);
        return 1 << ((k < w) ? k : (2 * w - 2 - k));
      end
      3: return (p % 2 == 0) ? 255 : 0;
      4: return (1 << (p % (w + 1))) - 1;
      default: return hv;
    endcase
  endfunction

  initial begin
    int n;
    int m_cnt, m_mq, m_p, m_hv, per;
    bit wrap_m, ev;

    ia.mode = 3'd0; ia.speed = 2'd2; ia.pause = 1'b0; ia.step = 1'b0;
    ib.mode = 3'd0; ib.speed = 2'd0; ib.pause = 1'b0; ib.step = 1'b0;

    // Rotate left at period 4 after reset.
    do_reset();
    chk("rst_ledr", 32'(ia.ledr), 32'h01);
    chk("rst_mode_q", 32'(ia.mode_q), 32'd0);
    chk("rst_tick", 32'(ia.tick), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      wait_tick(20, n);
      chk("rotl_gap", 32'(n), 32'd4);
      chk("rotl_ledr", 32'(ia.ledr), 32'(1 << (i % 8)));
    end

    // Pause mid-period, single-step three times, then resume from held count.
    do_reset();
    repeat (2) begin @(posedge clk); #1; end
    ia.pause = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("pause_tick", 32'(ia.tick), 32'd0);
      chk("pause_ledr", 32'(ia.ledr), 32'h01);
    end
    for (int k = 1; k <= 3; k++) begin
      ia.step = 1'b1;
      @(posedge clk); #1;
      ia.step = 1'b0;
      chk("step_tick", 32'(ia.tick), 32'd1);
      chk("step_ledr", 32'(ia.ledr), 32'(1 << k));
      @(posedge clk); #1;
      chk("step_tick_off", 32'(ia.tick), 32'd0);
    end
    ia.pause = 1'b0;
    wait_tick(20, n);
    chk("resume_gap", 32'(n), 32'd2);
    chk("resume_ledr", 32'(ia.ledr), 32'h10);

    // Speed 0 -> 3 while the count is at 10.
    ia.speed = 2'd0;
    do_reset();
    repeat (10) begin
      @(posedge clk); #1;
      chk("slow_no_tick", 32'(ia.tick), 32'd0);
    end
    ia.speed = 2'd3;
    @(posedge clk); #1;
    chk("speedup_tick", 32'(ia.tick), 32'd1);
    chk("speedup_ledr", 32'(ia.ledr), 32'h02);
    for (int k = 2; k <= 3; k++) begin
      wait_tick(20, n);
      chk("fast_gap", 32'(n), 32'd2);
      chk("fast_ledr", 32'(ia.ledr), 32'(1 << k));
    end
    ia.mode = 3'd6;
    for (int k = 0; k < 3; k++) begin
      wait_tick(20, n);
      chk("hold_gap", 32'(n), 32'd2);
      chk("hold_ledr", 32'(ia.ledr), 32'h08);
      chk("hold_mode_q", 32'(ia.mode_q), 32'd6);
    end

    // Asynchronous reset while blinking all-on.
    ia.mode = 3'd3;
    wait_tick(20, n);
    chk("blink_ledr", 32'(ia.ledr), 32'hFF);
    chk("blink_mode_q", 32'(ia.mode_q), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ledr", 32'(ia.ledr), 32'h01);
    chk("async_mode_q", 32'(ia.mode_q), 32'd0);
    chk("async_tick", 32'(ia.tick), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Vector table on the 4-bit, one-clock-period instance.
    tbl.push_back(mk(2,0,0, 4'h1,1,2)); tbl.push_back(mk(2,0,0, 4'h2,1,2));
    tbl.push_back(mk(2,0,0, 4'h4,1,2)); tbl.push_back(mk(2,0,0, 4'h8,1,2));
    tbl.push_back(mk(2,0,0, 4'h4,1,2)); tbl.push_back(mk(2,0,0, 4'h2,1,2));
    tbl.push_back(mk(2,0,0, 4'h1,1,2)); tbl.push_back(mk(2,0,0, 4'h2,1,2));
    tbl.push_back(mk(4,0,0, 4'h0,1,4)); tbl.push_back(mk(4,0,0, 4'h1,1,4));
    tbl.push_back(mk(4,0,0, 4'h3,1,4)); tbl.push_back(mk(4,0,0, 4'h7,1,4));
    tbl.push_back(mk(4,0,0, 4'hF,1,4)); tbl.push_back(mk(4,0,0, 4'h0,1,4));
    tbl.push_back(mk(4,0,0, 4'h1,1,4)); tbl.push_back(mk(4,1,0, 4'h1,0,4));
    tbl.push_back(mk(4,1,1, 4'h3,1,4)); tbl.push_back(mk(4,1,0, 4'h3,0,4));
    tbl.push_back(mk(4,0,1, 4'h7,1,4)); tbl.push_back(mk(6,0,0, 4'h7,1,6));
    tbl.push_back(mk(6,0,0, 4'h7,1,6)); tbl.push_back(mk(3,0,0, 4'hF,1,3));
    tbl.push_back(mk(3,0,0, 4'h0,1,3)); tbl.push_back(mk(3,0,0, 4'hF,1,3));
    tbl.push_back(mk(1,0,0, 4'h1,1,1)); tbl.push_back(mk(1,0,0, 4'h8,1,1));
    tbl.push_back(mk(1,0,0, 4'h4,1,1)); tbl.push_back(mk(0,0,0, 4'h1,1,0));
    tbl.push_back(mk(0,0,0, 4'h2,1,0));
    ib.mode = 3'd0; ib.pause = 1'b0; ib.step = 1'b0;
    do_reset();
    chk("tbl_rst_ledr", 32'(ib.ledr), 32'h1);
    foreach (tbl[i]) begin
      ib.mode = tbl[i].mode; ib.pause = tbl[i].pause; ib.step = tbl[i].step;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_ledr", i), 32'(ib.ledr), 32'(tbl[i].led));
      chk($sformatf("tbl%0d_tick", i), 32'(ib.tick), 32'(tbl[i].tick));
      chk($sformatf("tbl%0d_mode_q", i), 32'(ib.mode_q), 32'(tbl[i].mq));
    end

    // Randomised run against the reference model.
    ia.mode = 3'd0; ia.speed = 2'd2; ia.pause = 1'b0; ia.step = 1'b0;
    do_reset();
    m_cnt = 0; m_mq = 0; m_p = 0; m_hv = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) ia.mode = 3'($urandom_range(7));
      if ($urandom_range(31) == 0) ia.speed = 2'($urandom_range(3));
      ia.pause = ($urandom_range(3) == 0);
      ia.step  = 1'($urandom_range(1));
      per = 16 >> ia.speed;
      if (per < 1) per = 1;
      wrap_m = !ia.pause && (m_cnt >= per - 1);
      if (!ia.pause) m_cnt = wrap_m ? 0 : m_cnt + 1;
      ev = wrap_m || (ia.pause && ia.step);
      if (ev) begin
        if (int'(ia.mode) != m_mq) begin
          m_hv = model_led(m_mq, m_p, m_hv);
          m_mq = int'(ia.mode);
          m_p  = 0;
        end else begin
          m_p++;
        end
      end
      @(posedge clk); #1;
      chk("rnd_ledr", 32'(ia.ledr), 32'(model_led(m_mq, m_p, m_hv)));
      chk("rnd_tick", 32'(ia.tick), 32'(ev));
      chk("rnd_mode_q", 32'(ia.mode_q), 32'(m_mq));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
